// File: rtl/ps2_key_event_queue_pkg.sv
// Shared definitions for the PS/2 key event queue: prefix/reply byte codes,
// decoder states and the queued event record.
package ps2_pkg;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  localparam logic [7:0] RPL_AA = 8'hAA;
  localparam logic [7:0] RPL_FA = 8'hFA;
  localparam logic [7:0] RPL_FE = 8'hFE;
  localparam logic [7:0] RPL_EE = 8'hEE;
  localparam logic [7:0] RPL_00 = 8'h00;
  localparam logic [7:0] RPL_FF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_PAUSE
  } dec_state_t;

  typedef struct packed {
    logic        brk;
    logic [15:0] code;
  } key_event_t;

  function automatic logic is_reply(input logic [7:0] b);
    return (b == RPL_AA) || (b == RPL_FA) || (b == RPL_FE) ||
           (b == RPL_EE) || (b == RPL_00) || (b == RPL_FF);
  endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Valid/ready handshake carrying decoded key events to the CPU-side peripheral.
interface ps2_key_event_queue_if;
  logic [15:0] key_out;
  logic        key_break_out;
  logic        key_valid_out;
  logic        key_ready_in;

  modport master (output key_out, key_break_out, key_valid_out, input key_ready_in);
  modport slave  (input key_out, key_break_out, key_valid_out, output key_ready_in);
endinterface

// File: rtl/ps2_key_event_queue_fifo.sv
// Synchronous FIFO; the head is read straight from the storage array so a
// write at one edge is visible at the head in the following cycle.
module key_event_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             wr_en, rd_en;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  // A pop frees a slot in the same edge, so a full FIFO can still accept.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (wr_en && !rd_en)      count_reg <= count_reg + CW'(1);
      else if (!wr_en && rd_en) count_reg <= count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scancode prefix decoder (E0/F0/E1) feeding a key event FIFO, with
// controller reply bytes diverted to a separate ctrl strobe.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FILTER_CTRL = 1,
  parameter logic [15:0] PAUSE_CODE  = 16'hE177,
  localparam int         CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          global_clk,
  input  logic                          reset,
  input  logic [7:0]                    key_data_in,
  input  logic                          key_changed,
  ps2_key_event_queue_if.master         evt,
  output logic [CW-1:0]                 fifo_count,
  output logic                          overflow_out,
  input  logic                          overflow_clear,
  output logic                          ctrl_valid_out,
  output logic [7:0]                    ctrl_code_out,
  output logic                          proto_err_out
);

  dec_state_t state_reg, state_next;
  logic       ext_reg, ext_next;
  logic [2:0] skip_reg, skip_next;
  logic       push, divert, err;
  key_event_t push_evt, head;
  logic       full, empty;
  logic       overflow_reg, ctrl_valid_reg, proto_err_reg;
  logic [7:0] ctrl_code_reg;

  always_comb begin
    state_next = state_reg;
    ext_next   = ext_reg;
    skip_next  = skip_reg;
    push       = 1'b0;
    push_evt   = '0;
    divert     = 1'b0;
    err        = 1'b0;
    if (key_changed) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (key_data_in == PFX_E0) begin
            state_next = ST_EXT;
            ext_next   = 1'b1;
          end else if (key_data_in == PFX_F0) begin
            state_next = ST_BRK;
            ext_next   = 1'b0;
          end else if (key_data_in == PFX_E1) begin
            state_next = ST_PAUSE;
            skip_next  = 3'd7;
          end else if (FILTER_CTRL != 0 && is_reply(key_data_in)) begin
            divert = 1'b1;
          end else begin
            push     = 1'b1;
            push_evt = '{brk: 1'b0, code: {8'h00, key_data_in}};
          end
        end
        ST_EXT: begin
          if (key_data_in == PFX_F0) begin
            state_next = ST_BRK;
          end else if (key_data_in == PFX_E1) begin
            err        = 1'b1;
            state_next = ST_IDLE;
          end else if (key_data_in != PFX_E0) begin
            push       = 1'b1;
            push_evt   = '{brk: 1'b0, code: {PFX_E0, key_data_in}};
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (key_data_in == PFX_E0 || key_data_in == PFX_E1) begin
            err        = 1'b1;
            state_next = ST_IDLE;
          end else if (key_data_in != PFX_F0) begin
            push       = 1'b1;
            push_evt   = '{brk: 1'b1, code: {(ext_reg ? PFX_E0 : 8'h00), key_data_in}};
            state_next = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          // Bytes of the Pause sequence are counted, not interpreted.
          skip_next = skip_reg - 3'd1;
          if (skip_reg <= 3'd1) begin
            skip_next  = 3'd0;
            push       = 1'b1;
            push_evt   = '{brk: 1'b0, code: PAUSE_CODE};
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge global_clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      ext_reg        <= 1'b0;
      skip_reg       <= 3'd0;
      overflow_reg   <= 1'b0;
      ctrl_valid_reg <= 1'b0;
      ctrl_code_reg  <= 8'h00;
      proto_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ext_reg        <= ext_next;
      skip_reg       <= skip_next;
      ctrl_valid_reg <= divert;
      proto_err_reg  <= err;
      if (divert) ctrl_code_reg <= key_data_in;
      // A fresh drop wins over a simultaneous clear.
      if (push && full && !evt.key_ready_in) overflow_reg <= 1'b1;
      else if (overflow_clear)               overflow_reg <= 1'b0;
    end
  end

  key_event_fifo #(
    .WIDTH (17),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (global_clk),
    .srst      (reset),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt.key_ready_in),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign evt.key_out       = head.code;
  assign evt.key_break_out = head.brk;
  assign evt.key_valid_out = !empty;
  assign overflow_out      = overflow_reg;
  assign ctrl_valid_out    = ctrl_valid_reg;
  assign ctrl_code_out     = ctrl_code_reg;
  assign proto_err_out     = proto_err_reg;

endmodule
